// File: rtl/complex_row_feeder_pkg.sv
// Shared definitions for the complex row feeder: element geometry, zero element
// and the feeder state encoding.
package complex_pkg;

   localparam int element_width = 64;
   localparam int NI            = 8;

   // All-zero bits is also +0.0 for both float halves of a complex element.
   localparam logic [element_width-1:0] ZERO_ELEM = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/complex_row_feeder_if.sv
// Element stream into the row feeder: payload with a valid/ready handshake.
interface complex_row_feeder_if #(
   parameter int element_width = complex_pkg::element_width
) ();

   logic [element_width-1:0] in_data;
   logic                     in_valid;
   logic                     in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/complex_row_feeder_assembler.sv
// Fill register for one row: slot-indexed element writes, clear, and a merged
// view that already includes the element being written this cycle.
module complex_row_assembler #(
   parameter int element_width = complex_pkg::element_width,
   parameter int NI            = complex_pkg::NI,
   parameter int SLOT_W        = (NI > 1) ? $clog2(NI) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [SLOT_W-1:0]           wr_slot,
   input  logic [element_width-1:0]    wr_data,
   output logic [NI*element_width-1:0] merged_row
);

   logic [NI*element_width-1:0] fill_q;

   // Slots not yet written stay zero because the register is cleared at the
   // start of every row, which gives the padding of a short final row for free.
   always_comb begin
      merged_row = fill_q;
      for (int k = 0; k < NI; k++) begin
         if (wr_en && (wr_slot == SLOT_W'(k))) begin
            merged_row[k*element_width +: element_width] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         fill_q <= '0;
      end else if (wr_en) begin
         fill_q <= merged_row;
      end
   end

endmodule

// File: rtl/complex_row_feeder.sv
// Packs a serial stream of complex elements into NI-wide rows and sequences the
// start/row strobe/done signals for the downstream row accumulator.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for go; nothing accepted, start low
//   ST_FILL  | accepting elements, emitting one strobe per completed row
//   ST_DRAIN | last row sent; start held while the accumulator flushes
//   ST_DONE  | single-cycle done pulse, start low
module complex_row_feeder #(
   parameter int element_width = complex_pkg::element_width,
   parameter int NI            = complex_pkg::NI,
   parameter int LEN_W         = 16,
   parameter int DRAIN         = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic [LEN_W-1:0]            vec_len,
   complex_row_feeder_if.slave         in_s,
   output logic [NI*element_width-1:0] row_data,
   output logic                        row_valid,
   output logic                        row_last,
   output logic                        start,
   output logic                        busy,
   output logic                        done
);

   import complex_pkg::*;

   localparam int SLOT_W  = (NI > 1) ? $clog2(NI) : 1;
   localparam int DRAIN_W = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

   feeder_state_t state_q;
   feeder_state_t state_d;

   logic [LEN_W-1:0]            remaining_q;
   logic [SLOT_W-1:0]           slot_q;
   logic [DRAIN_W-1:0]          drain_q;
   logic [NI*element_width-1:0] row_q;
   logic                        row_valid_q;
   logic                        row_last_q;

   logic                        in_ready_c;
   logic                        launch;
   logic                        accept;
   logic                        last_elem;
   logic                        row_done;
   logic                        fill_clr;
   logic [NI*element_width-1:0] merged_row;

   assign launch    = (state_q == ST_IDLE) && go && (vec_len != '0);
   assign accept    = in_s.in_valid && (state_q == ST_FILL);
   assign last_elem = accept && (remaining_q == LEN_W'(1));
   assign row_done  = accept && ((slot_q == SLOT_W'(NI - 1)) || (remaining_q == LEN_W'(1)));
   assign fill_clr  = launch || row_done;

   complex_row_assembler #(
      .element_width (element_width),
      .NI            (NI),
      .SLOT_W        (SLOT_W)
   ) u_assembler (
      .clk        (clk),
      .rst        (rst),
      .clr        (fill_clr),
      .wr_en      (accept),
      .wr_slot    (slot_q),
      .wr_data    (in_s.in_data),
      .merged_row (merged_row)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      start      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (go) begin
               state_d = (vec_len == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            in_ready_c = 1'b1;
            start      = 1'b1;
            if (last_elem) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            start = 1'b1;
            if (drain_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The drain counter is loaded on the last accept, so DRAIN occupies the
   // strobe cycle plus DRAIN more before DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining_q <= '0;
         slot_q      <= '0;
         drain_q     <= '0;
         row_q       <= '0;
         row_valid_q <= 1'b0;
         row_last_q  <= 1'b0;
      end else begin
         row_valid_q <= row_done;
         row_last_q  <= last_elem;
         if (row_done) begin
            row_q <= merged_row;
         end
         if (launch) begin
            remaining_q <= vec_len;
            slot_q      <= '0;
         end else if (accept) begin
            remaining_q <= remaining_q - LEN_W'(1);
            slot_q      <= row_done ? '0 : slot_q + SLOT_W'(1);
         end
         if (last_elem) begin
            drain_q <= DRAIN_W'(DRAIN);
         end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
            drain_q <= drain_q - DRAIN_W'(1);
         end
      end
   end

   assign in_s.in_ready = in_ready_c;
   assign row_data      = row_q;
   assign row_valid     = row_valid_q;
   assign row_last      = row_last_q;

endmodule

// File: tb/tb_complex_row_feeder.sv
// Self-checking bench for complex_row_feeder: directed scenarios plus random
// vectors compared cycle by cycle against a row-grouping reference model.
module tb_complex_row_feeder;

   import complex_pkg::*;

   localparam int EW      = element_width;
   localparam int RW      = NI * EW;
   localparam int LEN_W   = 16;
   localparam int DRAIN_C = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             go;
   logic [LEN_W-1:0] vec_len;
   logic [RW-1:0]    row_data;
   logic             row_valid;
   logic             row_last;
   logic             start;
   logic             busy;
   logic             done;

   complex_row_feeder_if #(.element_width(EW)) in_if ();

   complex_row_feeder #(
      .element_width (EW),
      .NI            (NI),
      .LEN_W         (LEN_W),
      .DRAIN         (DRAIN_C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .vec_len   (vec_len),
      .in_s      (in_if),
      .row_data  (row_data),
      .row_valid (row_valid),
      .row_last  (row_last),
      .start     (start),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [RW-1:0] held_row = '0;

   task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_row_valid"}, RW'(row_valid), RW'(0));
      chk({tag, "_row_last"},  RW'(row_last),  RW'(0));
      chk({tag, "_start"},     RW'(start),     RW'(0));
      chk({tag, "_busy"},      RW'(busy),      RW'(0));
      chk({tag, "_done"},      RW'(done),      RW'(0));
      chk({tag, "_in_ready"},  RW'(in_if.in_ready), RW'(0));
      chk({tag, "_row_data"},  row_data,       RW'(0));
   endtask

   // vmode: 100 = continuous valid, -1 = valid toggling every cycle,
   // otherwise percent chance of valid per cycle. rst_at >= 0 resets after
   // that many accepted elements.
   task automatic run_vector(input int len, input int vmode, input bit seq_data,
                             input bit relaunch, input int rst_at);
      logic [EW-1:0] elems[$];
      logic [EW-1:0] dval;
      logic [RW-1:0] exp_row;
      int            acc = 0;
      int            k = -1;
      int            cyc = 0;
      bit            exp_rv = 1'b0;
      bit            exp_last = 1'b0;
      bit            drv_v;
      bit            relaunched = 1'b0;
      bit            fin = 1'b0;

      go = 1'b1;
      vec_len = LEN_W'(len);
      in_if.in_valid = 1'b0;
      @(posedge clk); #1;
      go = 1'b0;

      if (len == 0) begin
         chk("zl_done",  RW'(done),      RW'(1));
         chk("zl_start", RW'(start),     RW'(0));
         chk("zl_rv",    RW'(row_valid), RW'(0));
         @(posedge clk); #1;
         chk("zl_busy_after",  RW'(busy),      RW'(0));
         chk("zl_done_after",  RW'(done),      RW'(0));
         chk("zl_start_after", RW'(start),     RW'(0));
         chk("zl_rv_after",    RW'(row_valid), RW'(0));
         return;
      end

      while (!fin) begin
         // Observe the cycle that follows the last edge.
         chk("row_valid", RW'(row_valid), RW'(exp_rv));
         if (exp_rv) begin
            held_row = exp_row;
            chk("row_last", RW'(row_last), RW'(exp_last));
            if (exp_last) k = 0;
         end
         chk("row_data", row_data, held_row);
         chk("in_ready", RW'(in_if.in_ready), RW'(acc < len));
         chk("start", RW'(start), RW'((k < 0) || (k <= DRAIN_C)));
         chk("done",  RW'(done),  RW'(k == DRAIN_C + 1));
         chk("busy",  RW'(busy),  RW'(1));
         if (k == DRAIN_C + 1) begin
            fin = 1'b1;
         end else begin
            if ((rst_at >= 0) && (acc == rst_at)) begin
               rst = 1'b1;
               in_if.in_valid = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               in_if.in_valid = 1'b0;
               held_row = '0;
               chk_all_zero("rst_mid");
               repeat (NI) begin
                  @(posedge clk); #1;
                  chk("rst_no_strobe", RW'(row_valid), RW'(0));
                  chk("rst_idle_busy", RW'(busy),      RW'(0));
               end
               return;
            end
            if (vmode == 100)     drv_v = 1'b1;
            else if (vmode < 0)   drv_v = (cyc % 2) == 0;
            else                  drv_v = $urandom_range(0, 99) < vmode;
            dval = seq_data ? EW'(acc + 1) : {$urandom, $urandom};
            in_if.in_valid = drv_v;
            in_if.in_data  = dval;
            if (relaunch && !relaunched && (acc == 2)) begin
               go = 1'b1;
               vec_len = LEN_W'(3);
               relaunched = 1'b1;
            end
            @(posedge clk); #1;
            go = 1'b0;
            if (k >= 0) k++;
            exp_rv = 1'b0;
            if (drv_v && (acc < len)) begin
               elems.push_back(dval);
               acc++;
               if ((acc % NI == 0) || (acc == len)) begin
                  exp_rv   = 1'b1;
                  exp_last = (acc == len);
                  exp_row  = {NI{ZERO_ELEM}};
                  foreach (elems[j]) exp_row[j*EW +: EW] = elems[j];
                  elems.delete();
               end
            end
            cyc++;
            if (cyc > 5000) begin
               chk("timeout", RW'(cyc), RW'(0));
               fin = 1'b1;
            end
         end
      end

      in_if.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("end_busy",  RW'(busy),  RW'(0));
      chk("end_done",  RW'(done),  RW'(0));
      chk("end_start", RW'(start), RW'(0));
      chk("end_rv",    RW'(row_valid), RW'(0));
   endtask

   initial begin
      rst = 1'b1;
      go = 1'b0;
      vec_len = '0;
      in_if.in_valid = 1'b0;
      in_if.in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_vector(16, 100, 1'b1, 1'b0, -1);   // exact multiple
      run_vector(11, 100, 1'b1, 1'b0, -1);   // partial final row
      run_vector(0,  100, 1'b1, 1'b0, -1);   // zero length
      run_vector(8,  -1,  1'b1, 1'b0, -1);   // stalls
      run_vector(10, 100, 1'b1, 1'b1, -1);   // re-launch ignored
      run_vector(8,  100, 1'b1, 1'b0, 5);    // reset mid-fill
      run_vector(8,  100, 1'b1, 1'b0, -1);   // clean row after reset
      run_vector(1,  100, 1'b0, 1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         run_vector($urandom_range(1, 40), $urandom_range(30, 100), 1'b0, 1'b0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
